// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM encoding and the
// bundle of per-stage write/bubble controls.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_MEM_WAIT = 2'b01,
    HZ_ERR      = 2'b10
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_IDLE   = '{default: 1'b0};
  localparam hz_ctrl_t CTRL_FREEZE = '{mem_wb_flush: 1'b1, default: 1'b0};

  // Controls for a cycle with no memory stall; load-use outranks redirect so the
  // branch is re-resolved once its operand is available.
  function automatic hz_ctrl_t run_ctrl(input logic load_use, input logic redirect);
    hz_ctrl_t c;
    c = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
          default: 1'b0};
    if (load_use) begin
      c.pc_write    = 1'b0;
      c.if_id_write = 1'b0;
      c.id_ex_flush = 1'b1;
    end else if (redirect) begin
      c.if_id_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
module pipeline_hazard_ctrl_load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              load_use
);
  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubbles, ID redirects,
// data-memory freeze with timeout, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_redirect,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_flush,
  output logic              ex_mem_write,
  output logic              mem_wb_flush,
  output logic              mem_timeout_err,
  output logic [PERF_W-1:0] stall_count,
  output logic [1:0]        state_dbg
);
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  hz_state_e      state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           err_q, err_nxt;
  logic           load_use;
  hz_ctrl_t       ctrl;

  pipeline_hazard_ctrl_load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HZ_RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  // The RUN cycle that first sees the miss counts as wait cycle 1.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = err_q;
    case (state)
      HZ_RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt    = HZ_MEM_WAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      HZ_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt    = HZ_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WCW'(MEM_TIMEOUT)) begin
          state_nxt = HZ_ERR;
          err_nxt   = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = HZ_ERR;
    endcase
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    if (!rst) begin
      case (state)
        HZ_RUN:      ctrl = (mem_req && !mem_ready) ? CTRL_FREEZE : run_ctrl(load_use, id_redirect);
        HZ_MEM_WAIT: ctrl = mem_ready ? run_ctrl(load_use, id_redirect) : CTRL_FREEZE;
        default:     ctrl = CTRL_FREEZE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count <= '0;
    else if (!ctrl.pc_write && (stall_count != '1)) stall_count <= stall_count + 1'b1;
  end

  assign pc_write        = ctrl.pc_write;
  assign if_id_write     = ctrl.if_id_write;
  assign if_id_flush     = ctrl.if_id_flush;
  assign id_ex_write     = ctrl.id_ex_write;
  assign id_ex_flush     = ctrl.id_ex_flush;
  assign ex_mem_write    = ctrl.ex_mem_write;
  assign mem_wb_flush    = ctrl.mem_wb_flush;
  assign mem_timeout_err = err_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for single-cycle
// control decode, hand-written sequences for memory stall, timeout and reset.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_redirect, ex_mem_read, mem_req, mem_ready;

  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush;
  logic        mem_timeout_err;
  logic [15:0] stall_count;
  logic [1:0]  state_dbg;

  logic        pc_write4, if_id_write4, if_id_flush4, id_ex_write4, id_ex_flush4, ex_mem_write4, mem_wb_flush4;
  logic        mem_timeout_err4;
  logic [3:0]  stall_count4;
  logic [1:0]  state_dbg4;

  // Packed control order: pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f
  localparam logic [6:0] C_NORM   = 7'b1101010;
  localparam logic [6:0] C_REDIR  = 7'b1111010;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_IDLE   = 7'b0000000;

  wire [6:0] ctl  = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush};
  wire [6:0] ctl4 = {pc_write4, if_id_write4, if_id_flush4, id_ex_write4, id_ex_flush4, ex_mem_write4, mem_wb_flush4};

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_redirect(id_redirect), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
    .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write), .mem_wb_flush(mem_wb_flush),
    .mem_timeout_err(mem_timeout_err), .stall_count(stall_count), .state_dbg(state_dbg)
  );

  pipeline_hazard_ctrl #(.PERF_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_redirect(id_redirect), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write4),
    .if_id_write(if_id_write4), .if_id_flush(if_id_flush4), .id_ex_write(id_ex_write4),
    .id_ex_flush(id_ex_flush4), .ex_mem_write(ex_mem_write4), .mem_wb_flush(mem_wb_flush4),
    .mem_timeout_err(mem_timeout_err4), .stall_count(stall_count4), .state_dbg(state_dbg4)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       uses_rt, redir, mr;
    logic [4:0] ert;
    logic       req, rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[9];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 0; id_redirect = 0; ex_mem_read = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; id_redirect = v.redir;
    ex_mem_read = v.mr; ex_rt = v.ert; mem_req = v.req; mem_ready = v.rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"lu_rs",        5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, C_LU};
    vecs[1] = '{"zero_guard",   5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, C_NORM};
    vecs[2] = '{"rt_unused",    5'd4, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, C_NORM};
    vecs[3] = '{"lu_rt",        5'd4, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, C_LU};
    vecs[4] = '{"not_load",     5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, C_NORM};
    vecs[5] = '{"redirect",     5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_REDIR};
    vecs[6] = '{"lu_over_redir",5'd8, 5'd3, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, C_LU};
    vecs[7] = '{"mem_hit",      5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, C_NORM};
    vecs[8] = '{"redir_no_lu",  5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, C_REDIR};

    // Reset state, observed while rst is held
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_err", 32'(mem_timeout_err), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Decode table; three load-use vectors each add one stall cycle
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i]);
      #1;
      chk({"vec_", vecs[i].name}, 32'(ctl), 32'(vecs[i].exp));
      tick();
    end
    idle_inputs();
    #1;
    chk("table_state", 32'(state_dbg), 32'd0);
    chk("table_stall", 32'(stall_count), 32'd3);

    // Load-use stall lasts one cycle once the load moves on
    do_reset();
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    chk("lu1_ctl", 32'(ctl), 32'(C_LU));
    tick();
    ex_mem_read = 0;
    #1;
    chk("lu2_ctl", 32'(ctl), 32'(C_NORM));
    chk("lu2_stall", 32'(stall_count), 32'd1);

    // Memory wait: 3 frozen cycles then ready
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_ctl%0d", i), 32'(ctl), 32'(C_FREEZE));
      chk($sformatf("mw_state%0d", i), 32'(state_dbg), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    mem_ready = 1;
    #1;
    chk("mw_ready_ctl", 32'(ctl), 32'(C_NORM));
    chk("mw_ready_state", 32'(state_dbg), 32'd1);
    tick();
    idle_inputs();
    #1;
    chk("mw_done_state", 32'(state_dbg), 32'd0);
    chk("mw_done_stall", 32'(stall_count), 32'd3);

    // Load-use during a memory miss collapses into the freeze
    do_reset();
    mem_req = 1; mem_ready = 0; ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    chk("lu_mem_ctl", 32'(ctl), 32'(C_FREEZE));
    tick();
    // Async reset in MEM_WAIT
    #2;
    chk("pre_rst_state", 32'(state_dbg), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state_dbg), 32'd0);
    chk("async_rst_stall", 32'(stall_count), 32'd0);
    chk("async_rst_ctl", 32'(ctl), 32'(C_IDLE));
    idle_inputs();
    tick();
    rst = 1'b0;

    // Timeout: 16 frozen cycles reach ERR, then 4 more saturate the 4-bit counter
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      if (ctl !== C_FREEZE || state_dbg === 2'b10) begin
        chk($sformatf("to_wait%0d", i), {23'd0, state_dbg, ctl}, {23'd0, (i == 1) ? 2'b00 : 2'b01, C_FREEZE});
      end
      tick();
    end
    chk("to_state", 32'(state_dbg), 32'd2);
    chk("to_err", 32'(mem_timeout_err), 32'd1);
    chk("to_stall16", 32'(stall_count), 32'd16);
    mem_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("err_ctl", 32'(ctl), 32'(C_FREEZE));
    chk("err_sticky", 32'(mem_timeout_err), 32'd1);
    chk("err_state", 32'(state_dbg), 32'd2);
    chk("stall20", 32'(stall_count), 32'd20);
    chk("stall_sat4", 32'(stall_count4), 32'd15);
    chk("err4", 32'(mem_timeout_err4), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("err_clr", 32'(mem_timeout_err), 32'd0);
    chk("err_clr_state", 32'(state_dbg), 32'd0);
    chk("err_clr_stall4", 32'(stall_count4), 32'd0);
    idle_inputs();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ctl", 32'(ctl), 32'(C_NORM));
    chk("post_rst_ctl4", 32'(ctl4), 32'(C_NORM));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
